// File: rtl/prog_count_ras_pkg.sv
// prog_count_pkg: shared types and defaults for the RAT program counter with
// its return-address stack.
//   pc_op_t   - the single operation the PC performs in a cycle
//   pc_req_t  - the raw request lines from the control unit
//   pc_decode - priority encoder: INTR > RET > CALL > LD > INC > HOLD
//               (reset is handled separately, above everything)
package prog_count_pkg;

  localparam int unsigned PC_RESET_VEC_DFLT = 'h000;
  localparam int unsigned PC_ISR_VEC_DFLT   = 'h3FF;

  typedef enum logic [2:0] {
    PC_OP_HOLD,
    PC_OP_INC,
    PC_OP_LD,
    PC_OP_CALL,
    PC_OP_RET,
    PC_OP_INTR
  } pc_op_t;

  typedef struct packed {
    logic intr;
    logic ret;
    logic call;
    logic ld;
    logic inc;
  } pc_req_t;

  // Exactly one op wins; everything below it is dropped for this cycle.
  function automatic pc_op_t pc_decode(pc_req_t r);
    if (r.intr)      return PC_OP_INTR;
    else if (r.ret)  return PC_OP_RET;
    else if (r.call) return PC_OP_CALL;
    else if (r.ld)   return PC_OP_LD;
    else if (r.inc)  return PC_OP_INC;
    else             return PC_OP_HOLD;
  endfunction

endpackage

// File: rtl/prog_count_ras_if.sv
// prog_count_ras_if: request/status bundle between the control unit (master)
// and the program counter (slave).
//   PC_INC/PC_LD/PC_CALL/PC_RET/PC_INTR  requests, master -> slave
//   PC_DIN                               jump/call target
//   PC_COUNT                             registered PC
//   PC_RAS_EMPTY/PC_RAS_FULL             registered stack status
//   PC_RAS_ERR                           sticky stack error (only with PC_RAS_ERR_EN)
interface prog_count_ras_if #(
  parameter int ADDR_W = 10
) ();
  logic              PC_INC;
  logic              PC_LD;
  logic              PC_CALL;
  logic              PC_RET;
  logic              PC_INTR;
  logic [ADDR_W-1:0] PC_DIN;
  logic [ADDR_W-1:0] PC_COUNT;
  logic              PC_RAS_EMPTY;
  logic              PC_RAS_FULL;
`ifdef PC_RAS_ERR_EN
  logic              PC_RAS_ERR;
`endif

  modport master (
    output PC_INC, PC_LD, PC_CALL, PC_RET, PC_INTR, PC_DIN,
`ifdef PC_RAS_ERR_EN
    input  PC_RAS_ERR,
`endif
    input  PC_COUNT, PC_RAS_EMPTY, PC_RAS_FULL
  );

  modport slave (
    input  PC_INC, PC_LD, PC_CALL, PC_RET, PC_INTR, PC_DIN,
`ifdef PC_RAS_ERR_EN
    output PC_RAS_ERR,
`endif
    output PC_COUNT, PC_RAS_EMPTY, PC_RAS_FULL
  );
endinterface

// File: rtl/prog_count_ras_ret_addr_stack.sv
// ret_addr_stack: circular LIFO of return addresses.
//   clk, rst    clock, synchronous active-high reset (clears depth only)
//   push        write push_data at the write pointer (even when full)
//   pop         remove top entry; ignored when empty
//   top_data    current top entry (valid when !empty)
//   empty/full  registered, reflect depth after the edge
// When full, the write pointer has wrapped onto the oldest entry, so a push
// simply overwrites it and depth saturates at RAS_DEPTH.
module ret_addr_stack #(
  parameter int ADDR_W    = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int DEP_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [DEP_W-1:0]  depth, depth_nxt;
  logic [PTR_W-1:0]  ptr_nxt;

  assign top_data = mem[wr_ptr - PTR_W'(1)];

  always_comb begin
    depth_nxt = depth;
    ptr_nxt   = wr_ptr;
    if (push) begin
      ptr_nxt = wr_ptr + PTR_W'(1);
      if (!full) depth_nxt = depth + DEP_W'(1);
    end else if (pop && !empty) begin
      ptr_nxt   = wr_ptr - PTR_W'(1);
      depth_nxt = depth - DEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      depth  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= ptr_nxt;
      depth  <= depth_nxt;
      empty  <= (depth_nxt == '0);
      full   <= (depth_nxt == DEP_W'(RAS_DEPTH));
    end
  end

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prog_count_ras.sv
// prog_count_ras: RAT CPU program counter with integrated return-address stack.
//   PC_CLK   clock, rising edge
//   PC_RST   synchronous active-high reset, overrides all requests
//   bus      prog_count_ras_if.slave: requests, PC_DIN, PC_COUNT, stack status
// One op per cycle: RST > INTR > RET > CALL > LD > INC > hold.
// CALL pushes PC+1 (mod 2^ADDR_W); INTR pushes PC itself; RET on an empty
// stack holds the PC.
// Optional macro PC_RAS_ERR_EN adds bus.PC_RAS_ERR, a sticky flag set on
// push-when-full or pop-when-empty and cleared only by PC_RST.
module prog_count_ras
  import prog_count_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          RAS_DEPTH = 8,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DFLT,
  parameter int unsigned ISR_VEC   = PC_ISR_VEC_DFLT
) (
  input logic              PC_CLK,
  input logic              PC_RST,
  prog_count_ras_if.slave  bus
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] ISR_PC = ADDR_W'(ISR_VEC);

  pc_req_t           req;
  pc_op_t            op;
  logic [ADDR_W-1:0] pc_q;
  logic              push, pop;
  logic [ADDR_W-1:0] push_data, ras_top;
  logic              ras_empty, ras_full;

  assign req = '{intr: bus.PC_INTR, ret: bus.PC_RET, call: bus.PC_CALL,
                 ld: bus.PC_LD, inc: bus.PC_INC};
  assign op  = pc_decode(req);

  assign push      = (op == PC_OP_CALL) || (op == PC_OP_INTR);
  assign pop       = (op == PC_OP_RET);
  assign push_data = (op == PC_OP_CALL) ? pc_q + ADDR_W'(1) : pc_q;

  ret_addr_stack #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (PC_CLK),
    .rst       (PC_RST),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge PC_CLK) begin
    if (PC_RST) begin
      pc_q <= RST_PC;
    end else begin
      unique case (op)
        PC_OP_INTR: pc_q <= ISR_PC;
        PC_OP_RET:  if (!ras_empty) pc_q <= ras_top;
        PC_OP_CALL: pc_q <= bus.PC_DIN;
        PC_OP_LD:   pc_q <= bus.PC_DIN;
        PC_OP_INC:  pc_q <= pc_q + ADDR_W'(1);
        default:    pc_q <= pc_q;
      endcase
    end
  end

  assign bus.PC_COUNT     = pc_q;
  assign bus.PC_RAS_EMPTY = ras_empty;
  assign bus.PC_RAS_FULL  = ras_full;

`ifdef PC_RAS_ERR_EN
  logic err_q;
  always_ff @(posedge PC_CLK) begin
    if (PC_RST)                                   err_q <= 1'b0;
    else if ((push && ras_full) || (pop && ras_empty)) err_q <= 1'b1;
  end
  assign bus.PC_RAS_ERR = err_q;
`endif

endmodule

// File: tb/tb_prog_count_ras.sv
module tb_prog_count_ras;
  localparam int AW = 10;

  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_RST  = 6'b100000;
  localparam logic [5:0] O_INTR = 6'b010000;
  localparam logic [5:0] O_RET  = 6'b001000;
  localparam logic [5:0] O_CALL = 6'b000100;
  localparam logic [5:0] O_LD   = 6'b000010;
  localparam logic [5:0] O_INC  = 6'b000001;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          e;
    logic          f;
    logic          chk_err;
    logic          err;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  exp_t  sb[$];
  string sb_nm[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  prog_count_ras_if #(.ADDR_W(AW)) ras_if ();

  prog_count_ras #(.ADDR_W(AW), .RAS_DEPTH(8)) dut (
    .PC_CLK (clk),
    .PC_RST (rst),
    .bus    (ras_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so compare on the falling edge after
  // each issued operation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  x;
      string nm;
      x  = sb.pop_front();
      nm = sb_nm.pop_front();
      chk({nm, ".pc"},    int'(ras_if.PC_COUNT),     int'(x.pc));
      chk({nm, ".empty"}, int'(ras_if.PC_RAS_EMPTY), int'(x.e));
      chk({nm, ".full"},  int'(ras_if.PC_RAS_FULL),  int'(x.f));
`ifdef PC_RAS_ERR_EN
      if (x.chk_err) chk({nm, ".err"}, int'(ras_if.PC_RAS_ERR), int'(x.err));
`endif
    end
  end

  // err < 0 means the error flag is not checked for this step.
  task automatic step(input logic [5:0] op, input logic [AW-1:0] din,
                      input logic [AW-1:0] pc, input logic e, input logic f,
                      input int err, input string nm);
    exp_t x;
    rst            = op[5];
    ras_if.PC_INTR = op[4];
    ras_if.PC_RET  = op[3];
    ras_if.PC_CALL = op[2];
    ras_if.PC_LD   = op[1];
    ras_if.PC_INC  = op[0];
    ras_if.PC_DIN  = din;
    @(posedge clk);
    #1;
    x.pc = pc; x.e = e; x.f = f;
    x.chk_err = (err >= 0);
    x.err     = (err > 0);
    sb.push_back(x);
    sb_nm.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    ras_if.PC_INTR = 1'b0; ras_if.PC_RET = 1'b0; ras_if.PC_CALL = 1'b0;
    ras_if.PC_LD   = 1'b0; ras_if.PC_INC = 1'b0; ras_if.PC_DIN  = '0;

    step(O_RST, 10'h000, 10'h000, 1, 0, 0, "reset");
    step(O_INC, 10'h000, 10'h001, 1, 0, -1, "inc1");
    step(O_INC, 10'h000, 10'h002, 1, 0, -1, "inc2");
    step(O_INC, 10'h000, 10'h003, 1, 0, -1, "inc3");
    step(O_RST | O_LD, 10'h055, 10'h000, 1, 0, 0, "rst_over_ld");

    step(O_LD,   10'h010, 10'h010, 1, 0, -1, "ld_010");
    step(O_CALL, 10'h200, 10'h200, 0, 0, -1, "call_200");
    step(O_RET,  10'h000, 10'h011, 1, 0, -1, "ret_011");

    step(O_LD,   10'h3FF, 10'h3FF, 1, 0, -1, "ld_3ff");
    step(O_INC,  10'h000, 10'h000, 1, 0, -1, "inc_wrap");
    step(O_LD,   10'h3FF, 10'h3FF, 1, 0, -1, "ld_3ff_b");
    step(O_CALL, 10'h100, 10'h100, 0, 0, -1, "call_wrap");
    step(O_RET,  10'h000, 10'h000, 1, 0, 0, "ret_wrap");

    // Fill and overflow: CALL from PC k to k+1 pushes k+1.
    step(O_LD, 10'h000, 10'h000, 1, 0, -1, "ld_000");
    for (int k = 0; k < 9; k++)
      step(O_CALL, AW'(k + 1), AW'(k + 1), 0, (k >= 7), (k == 8) ? 1 : 0,
           $sformatf("call_fill%0d", k));
    // Ninth push overwrote the oldest (1): pops give 9..2, then empty.
    for (int k = 0; k < 8; k++)
      step(O_RET, 10'h000, AW'(9 - k), (k == 7), 0, -1,
           $sformatf("ret_drain%0d", k));
    step(O_RET, 10'h000, 10'h002, 1, 0, 1, "ret_underflow");

    // Priority: INTR beats CALL/INC, only one entry pushed.
    step(O_LD, 10'h040, 10'h040, 1, 0, -1, "ld_040");
    step(O_INTR | O_CALL | O_INC, 10'h123, 10'h3FF, 0, 0, -1, "intr_prio");
    step(O_RET, 10'h000, 10'h040, 1, 0, -1, "ret_intr");
    step(O_RET, 10'h000, 10'h040, 1, 0, 1, "ret_empty_hold");

    // Priority: RET beats CALL/LD, CALL pushes nothing then.
    step(O_RST, 10'h000, 10'h000, 1, 0, 0, "reset2");
    step(O_LD,   10'h050, 10'h050, 1, 0, -1, "ld_050");
    step(O_CALL, 10'h060, 10'h060, 0, 0, -1, "call_060");
    step(O_RET | O_CALL | O_LD, 10'h070, 10'h051, 1, 0, 0, "ret_prio");

    // Reset in the middle of nested calls discards the stack.
    step(O_LD,   10'h020, 10'h020, 1, 0, -1, "ld_020");
    step(O_CALL, 10'h100, 10'h100, 0, 0, -1, "nest1");
    step(O_CALL, 10'h200, 10'h200, 0, 0, -1, "nest2");
    step(O_RST,  10'h000, 10'h000, 1, 0, 0, "rst_nested");
    step(O_RET,  10'h000, 10'h000, 1, 0, -1, "ret_after_rst");
    step(O_NONE, 10'h000, 10'h000, 1, 0, -1, "hold");

    @(posedge clk);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
